recipe_checker: RTL and testbench
=================================

# recipe_checker

Round controller for the cake game. It walks the cake ROM address by address and captures each 7-bit ingredient pattern from the ROM's one-cycle registered read. It then compares the pattern against the player's debounced ingredient press and reports win, wrong-ingredient or timeout. It sits between the input conditioning logic (upstream) and the cake ROM, whose `address`/`data_out` it drives and consumes.

## Interface
Parameters:
- `ADDR_W`, 3: ROM address / step width.
- `DATA_W`, 7: ingredient pattern width.
- `TIMEOUT`, 5000: maximum cycles allowed per step in WAIT_IN; must be ≥ 2.

Ports:
- `clock`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high; wins over every other input.
- `start`  in  1: one-cycle pulse; begins a round from IDLE, WIN or FAIL.
- `last_step`  in  ADDR_W: index of the final recipe step; sampled only on an accepted `start`.
- `play_valid`  in  1: one-cycle pulse, player confirmed an ingredient.
- `play_data`  in  DATA_W: ingredient buttons, qualified by `play_valid`.
- `rom_address`  out  ADDR_W: to ROM `address`; equals current `step`.
- `rom_data`  in  DATA_W: from ROM `data_out`; valid one cycle after an address is presented.
- `step`  out  ADDR_W: current step index.
- `expected`  out  DATA_W: latched pattern for the current step (drives the hint LEDs).
- `busy`  out  1: high in FETCH, LOAD, WAIT_IN.
- `win`  out  1: high in WIN.
- `lose_wrong`  out  1: high in FAIL when caused by a mismatch.
- `lose_timeout`  out  1: high in FAIL when caused by a timeout.

## Operation
- States: IDLE, FETCH, LOAD, WAIT_IN, WIN, FAIL.
- Reset value of every output is 0. `step` and `expected` are 0. The state is IDLE and the timer is 0.
- IDLE:
  - `start` → FETCH.
  - Clears `step` to 0 and latches `last_step`.
- FETCH: one cycle. `rom_address`=`step` is sampled by the ROM at the closing edge. Always → LOAD.
- LOAD: one cycle. `rom_data` is valid; `expected` ← `rom_data` at the closing edge. Timer ← 0. Always → WAIT_IN.
- WAIT_IN, evaluated in this priority order:
  1. `play_valid` with `play_data`==`expected`, and `step`==latched last: → WIN.
  2. `play_valid` with `play_data`==`expected`, otherwise: `step`+1 → FETCH.
  3. `play_valid` with `play_data`≠`expected` (including non-one-hot or zero data): → FAIL with `lose_wrong`.
  4. No `play_valid` and timer==TIMEOUT−1: → FAIL with `lose_timeout`.
  5. Otherwise the timer increments.
- Simultaneous `play_valid` and timeout: the input is evaluated; the timeout is not flagged.
- WIN / FAIL:
  - Hold all outputs until `start` or `reset`.
  - `start` → FETCH with `step`=0, flags cleared and `last_step` relatched.
- `start` in FETCH, LOAD or WAIT_IN is ignored. `play_valid` outside WAIT_IN is ignored.
- `step` never wraps inside a round: it stops at the latched `last_step`. With `last_step`=7 the full ROM is walked. With `last_step`=0 it is a single-step round.
- `reset` mid-round: next edge returns to the full reset state. No partial flags survive.
- Each lose flag is mutually exclusive with `win` and with the other lose flag.

## Timing
- `start` accepted at edge N: FETCH in cycle N+1, LOAD in N+2, `expected` valid and WAIT_IN from N+3.
- Per subsequent step: a correct press at edge M gives FETCH at M+1 and `expected` updated and WAIT_IN from M+3. `step` changes at edge M.
- Result flags assert in the cycle after the deciding edge; they are registered, with no combinational path from `play_*`.
- Maximum WAIT_IN dwell is exactly TIMEOUT cycles. A press in the TIMEOUT-th cycle still counts.
- `rom_address` is registered and is therefore stable throughout FETCH and LOAD.

## Structure
- Shared include `bitbakery_defs.vh` holds:
  - the state encoding localparams, 3-bit binary, IDLE=0;
  - the default `ADDR_W`/`DATA_W`, shared with the ROM.
- Sub-module `step_timer`: holds clear/enable, counter width `$clog2(TIMEOUT)`, and produces the `expired` output at TIMEOUT−1.
- FSM, step counter and `expected` register live in `recipe_checker`.

## Test plan
- Reset, then `start`, `last_step`=2, correct presses `0000001`, `0000010`, `0000100` → `win`=1 after the third press, `step`=2, `busy`=0.
- `start`, `last_step`=7, press at step 3 with `0000100` when the expected pattern is `0001000` → `lose_wrong`=1, `step`=3, `win`=0.
- `start`, no presses (TIMEOUT=8) → `lose_timeout`=1 exactly 8 cycles after WAIT_IN entry. A correct press in the 8th cycle instead advances to step 1.
- `start`, `last_step`=7, correct presses for all 8 steps → `expected` sequence 01,02,04,08,10,20,01,02 (hex), ending in `win`. `start` pulses and `play_valid` during FETCH/LOAD are ignored.
- `reset` asserted in WAIT_IN at step 4 → next cycle all outputs 0 and state IDLE. `start` from WIN restarts at step 0 with flags cleared.

Source files
------------

// File: rtl/recipe_checker_pkg.sv
// Shared definitions for the cake-game round controller: state encoding,
// default ROM geometry and the registered status flag bundle.
package recipe_checker_pkg;

    // Default ROM geometry, shared with the cake ROM.
    localparam int unsigned DEF_ADDR_W = 3;
    localparam int unsigned DEF_DATA_W = 7;

    // Round controller states, 3-bit binary, IDLE at zero.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_WAIT_IN = 3'd3,
        ST_WIN     = 3'd4,
        ST_FAIL    = 3'd5
    } state_t;

    // Status flags presented to the game shell.
    typedef struct packed {
        logic busy;
        logic win;
        logic lose_wrong;
        logic lose_timeout;
    } status_t;

endpackage

// File: rtl/recipe_checker_step_timer.sv
// Per-step dwell timer for WAIT_IN.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   clear        : force the count back to zero
//   enable       : count one cycle
//   expired      : registered, high while the count equals TIMEOUT-1
module recipe_checker_step_timer #(
    parameter int unsigned TIMEOUT = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_d;

    // Next count; saturates at the terminal value.
    always_comb begin
        count_d = count;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count + CNT_W'(1);
        end
    end

    // expired is registered alongside the count so it tracks count==TIMEOUT-1.
    always_ff @(posedge clock) begin
        if (reset) begin
            count   <= '0;
            expired <= 1'b0;
        end else begin
            count   <= count_d;
            expired <= (count_d == CNT_W'(TIMEOUT - 1));
        end
    end

endmodule

// File: rtl/recipe_checker.sv
// Round controller for the cake game: walks the cake ROM one step at a time,
// latches each ingredient pattern and checks it against the player's press.
// Ports:
//   clock, reset              : clock and synchronous active-high reset
//   start, last_step          : begin a round; index of the final step
//   play_valid, play_data     : player press strobe and ingredient buttons
//   rom_address, rom_data     : cake ROM address out, registered read data in
//   step, expected            : current step index and its latched pattern
//   busy, win, lose_wrong, lose_timeout : registered round status
module recipe_checker
    import recipe_checker_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = 5000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] last_step,
    input  logic              play_valid,
    input  logic [DATA_W-1:0] play_data,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] step,
    output logic [DATA_W-1:0] expected,
    output logic              busy,
    output logic              win,
    output logic              lose_wrong,
    output logic              lose_timeout
);

    state_t            state;
    state_t            next_state;
    status_t           status_q;
    status_t           status_d;
    logic [ADDR_W-1:0] step_q;
    logic [ADDR_W-1:0] last_q;
    logic [DATA_W-1:0] expected_q;
    logic              expired;
    logic              match;
    logic              at_last;
    logic              start_ok;

    assign match    = (play_data == expected_q);
    assign at_last  = (step_q == last_q);
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_WIN) || (state == ST_FAIL));

    recipe_checker_step_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_step_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == ST_LOAD),
        .enable  (state == ST_WAIT_IN),
        .expired (expired)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a press outranks a simultaneous timeout.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE, ST_WIN, ST_FAIL: begin
                if (start) next_state = ST_FETCH;
            end
            ST_FETCH: next_state = ST_LOAD;
            ST_LOAD:  next_state = ST_WAIT_IN;
            ST_WAIT_IN: begin
                if (play_valid) begin
                    if (match) begin
                        next_state = at_last ? ST_WIN : ST_FETCH;
                    end else begin
                        next_state = ST_FAIL;
                    end
                end else if (expired) begin
                    next_state = ST_FAIL;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Status for the coming cycle; the FAIL cause is decided on WAIT_IN exit and then held.
    always_comb begin
        status_d = '0;
        unique case (next_state)
            ST_FETCH, ST_LOAD, ST_WAIT_IN: status_d.busy = 1'b1;
            ST_WIN:                        status_d.win  = 1'b1;
            ST_FAIL: begin
                if (state == ST_WAIT_IN) begin
                    status_d.lose_wrong   = play_valid;
                    status_d.lose_timeout = !play_valid;
                end else begin
                    status_d = status_q;
                end
            end
            default: status_d = '0;
        endcase
    end

    // Status flag register.
    always_ff @(posedge clock) begin
        if (reset) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    // Step counter, round length and ROM pattern capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            step_q     <= '0;
            last_q     <= '0;
            expected_q <= '0;
        end else begin
            if (start_ok) begin
                step_q <= '0;
                last_q <= last_step;
            end else if ((state == ST_WAIT_IN) && (next_state == ST_FETCH)) begin
                step_q <= step_q + ADDR_W'(1);
            end
            if (state == ST_LOAD) begin
                expected_q <= rom_data;
            end
        end
    end

    assign rom_address  = step_q;
    assign step         = step_q;
    assign expected     = expected_q;
    assign busy         = status_q.busy;
    assign win          = status_q.win;
    assign lose_wrong   = status_q.lose_wrong;
    assign lose_timeout = status_q.lose_timeout;

endmodule

// File: tb/tb_recipe_checker.sv
// Scoreboard bench for recipe_checker: the driver pushes hand-computed
// expectations, monitors pop them when the DUT enters WAIT_IN, raises a
// result flag, or comes out of reset.
module tb_recipe_checker;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 7;

    typedef struct {
        logic [2:0] step;
        logic [6:0] pat;
    } fetch_t;

    typedef struct {
        logic [3:0] flags;   // {busy, win, lose_wrong, lose_timeout}
        logic [2:0] step;
        logic [6:0] pat;
        int         dwell;   // cycles from WAIT_IN entry to flag, -1 = unchecked
    } res_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] last_step = '0;
    logic              play_valid = 1'b0;
    logic [DATA_W-1:0] play_data = '0;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_data;
    logic [ADDR_W-1:0] step;
    logic [DATA_W-1:0] expected;
    logic              busy, win, lose_wrong, lose_timeout;

    fetch_t fq[$];
    res_t   rq[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    logic [6:0] pat_tab [8];

    always #5 clock = ~clock;

    recipe_checker #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .last_step    (last_step),
        .play_valid   (play_valid),
        .play_data    (play_data),
        .rom_address  (rom_address),
        .rom_data     (rom_data),
        .step         (step),
        .expected     (expected),
        .busy         (busy),
        .win          (win),
        .lose_wrong   (lose_wrong),
        .lose_timeout (lose_timeout)
    );

    // Cake ROM model with one-cycle registered read.
    always @(posedge clock) rom_data <= pat_tab[rom_address];

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic       rst_seen = 1'b0;
    logic       busy_prev = 1'b0;
    logic       res_prev = 1'b0;
    logic [2:0] step_prev = '0;
    int         pend = 0;
    int         cyc = 0;
    int         wait_cyc = 0;

    always @(posedge clock) rst_seen <= reset;

    task automatic pop_result();
        res_t r;
        if (rq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL result_pop: got unexpected result flags %b, want none", {busy, win, lose_wrong, lose_timeout});
        end else begin
            r = rq.pop_front();
            chk("res_flags", int'({busy, win, lose_wrong, lose_timeout}), int'(r.flags));
            chk("res_step", int'(step), int'(r.step));
            chk("res_addr", int'(rom_address), int'(r.step));
            chk("res_expected", int'(expected), int'(r.pat));
            if (r.dwell >= 0) chk("res_dwell", cyc - wait_cyc, r.dwell);
        end
    endtask

    task automatic pop_fetch();
        fetch_t f;
        if (fq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fetch_pop: got unexpected step %0d entry, want none", step);
        end else begin
            f = fq.pop_front();
            chk("wait_step", int'(step), int'(f.step));
            chk("wait_addr", int'(rom_address), int'(f.step));
            chk("wait_expected", int'(expected), int'(f.pat));
            chk("wait_flags", int'({busy, win, lose_wrong, lose_timeout}), int'(4'b1000));
        end
    endtask

    always @(negedge clock) begin
        logic res_now;
        cyc++;
        res_now = win | lose_wrong | lose_timeout;
        if (rst_seen) begin
            pend = 0;
            pop_result();
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    wait_cyc = cyc;
                    pop_fetch();
                end
            end
            if (res_now && !res_prev) pop_result();
            if (busy && (!busy_prev || step != step_prev)) pend = 2;
        end
        busy_prev = busy;
        step_prev = step;
        res_prev  = res_now;
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic exp_fetch(input logic [2:0] s, input logic [6:0] p);
        fq.push_back('{step: s, pat: p});
    endtask

    task automatic exp_res(input logic [3:0] f, input logic [2:0] s, input logic [6:0] p, input int d);
        rq.push_back('{flags: f, step: s, pat: p, dwell: d});
    endtask

    // Starts a round at a negedge; returns at the first WAIT_IN negedge.
    task automatic start_round(input logic [2:0] ls, input logic [6:0] p0, input bit noise);
        exp_fetch(3'd0, p0);
        start = 1'b1;
        last_step = ls;
        tick();
        start = 1'b0;
        if (noise) begin
            start = 1'b1;
            last_step = ~ls;
            play_valid = 1'b1;
            play_data = 7'h7f;
        end
        tick();
        tick();
        start = 1'b0;
        play_valid = 1'b0;
    endtask

    // Presses after idle WAIT_IN cycles; with advance, returns at the next WAIT_IN negedge.
    task automatic press(input logic [6:0] d, input int idle, input bit advance, input bit noise);
        repeat (idle) tick();
        play_valid = 1'b1;
        play_data = d;
        tick();
        play_valid = 1'b0;
        if (advance) begin
            if (noise) begin
                start = 1'b1;
                last_step = 3'd5;
                play_valid = 1'b1;
                play_data = 7'h00;
            end
            tick();
            tick();
            start = 1'b0;
            play_valid = 1'b0;
        end
    endtask

    localparam logic [3:0] F_IDLE = 4'b0000;
    localparam logic [3:0] F_WIN  = 4'b0100;
    localparam logic [3:0] F_LW   = 4'b0010;
    localparam logic [3:0] F_LT   = 4'b0001;

    initial begin
        pat_tab = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h01, 7'h02};

        // Reset state.
        exp_res(F_IDLE, 3'd0, 7'h00, -1);
        tick();
        reset = 1'b0;
        tick();

        // Three-step round ending in a win.
        start_round(3'd2, 7'h01, 1'b0);
        exp_fetch(3'd1, 7'h02);
        press(7'b0000001, 0, 1'b1, 1'b0);
        exp_fetch(3'd2, 7'h04);
        press(7'b0000010, 1, 1'b1, 1'b1);
        exp_res(F_WIN, 3'd2, 7'h04, -1);
        press(7'b0000100, 0, 1'b0, 1'b0);
        repeat (2) tick();

        // Restart from WIN; wrong ingredient at step 3.
        start_round(3'd7, 7'h01, 1'b1);
        exp_fetch(3'd1, 7'h02);
        press(7'h01, 0, 1'b1, 1'b1);
        exp_fetch(3'd2, 7'h04);
        press(7'h02, 2, 1'b1, 1'b0);
        exp_fetch(3'd3, 7'h08);
        press(7'h04, 0, 1'b1, 1'b0);
        exp_res(F_LW, 3'd3, 7'h08, -1);
        press(7'b0000100, 3, 1'b0, 1'b0);
        tick();

        // Timeout: flag exactly 8 cycles after WAIT_IN entry.
        start_round(3'd0, 7'h01, 1'b0);
        exp_res(F_LT, 3'd0, 7'h01, 8);
        repeat (10) tick();

        // Press in the 8th WAIT_IN cycle still counts.
        start_round(3'd1, 7'h01, 1'b0);
        exp_fetch(3'd1, 7'h02);
        press(7'h01, 7, 1'b1, 1'b0);
        exp_res(F_WIN, 3'd1, 7'h02, 1);
        press(7'h02, 0, 1'b0, 1'b0);
        tick();

        // Full ROM walk with ignored start/press noise in every FETCH/LOAD.
        start_round(3'd7, 7'h01, 1'b1);
        for (int i = 1; i < 8; i++) begin
            exp_fetch(3'(i), pat_tab[i]);
            press(pat_tab[i-1], i % 3, 1'b1, 1'b1);
        end
        exp_res(F_WIN, 3'd7, 7'h02, -1);
        press(7'h02, 0, 1'b0, 1'b0);
        tick();

        // Reset mid-round at step 4.
        start_round(3'd7, 7'h01, 1'b0);
        for (int i = 1; i < 5; i++) begin
            exp_fetch(3'(i), pat_tab[i]);
            press(pat_tab[i-1], 0, 1'b1, 1'b0);
        end
        repeat (2) tick();
        exp_res(F_IDLE, 3'd0, 7'h00, -1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (2) tick();

        // Non-one-hot and zero presses are wrong ingredients.
        start_round(3'd0, 7'h01, 1'b0);
        exp_res(F_LW, 3'd0, 7'h01, -1);
        press(7'h03, 0, 1'b0, 1'b0);
        tick();
        start_round(3'd0, 7'h01, 1'b0);
        exp_res(F_LW, 3'd0, 7'h01, 3);
        press(7'h00, 2, 1'b0, 1'b0);
        repeat (4) tick();

        chk("fetch_queue_left", fq.size(), 0);
        chk("result_queue_left", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
